// File: rtl/pe_scratchpad_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : pe_scratchpad_responder_if
//  Purpose  : Request/response bundle between the PE controller (master)
//             and the scratchpad responder (slave), including the
//             partial-sum clear handshake.
//  Revision : 1.0 - initial release
// ============================================================================
interface pe_scratchpad_responder_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 9
) ();
    logic                     read_request;
    logic [ADDRESS_WIDTH-1:0] read_address;
    logic                     write_enable;
    logic [ADDRESS_WIDTH-1:0] write_address;
    logic [DATA_WIDTH-1:0]    write_data;
    logic [DATA_WIDTH-1:0]    read_data;
    logic                     read_valid;
    logic                     addr_error;
    logic                     ready;
    logic                     clear_start;
    logic                     clear_busy;
    logic                     clear_done;

    // PE controller side
    modport master (
        output read_request, read_address,
        output write_enable, write_address, write_data,
        output clear_start,
        input  read_data, read_valid, addr_error, ready,
        input  clear_busy, clear_done
    );

    // Scratchpad responder side
    modport slave (
        input  read_request, read_address,
        input  write_enable, write_address, write_data,
        input  clear_start,
        output read_data, read_valid, addr_error, ready,
        output clear_busy, clear_done
    );
endinterface
`default_nettype wire

// File: rtl/pe_scratchpad_responder.sv
`default_nettype none
// ============================================================================
//  Module   : pe_scratchpad_responder
//  Purpose  : Scratchpad memory responder for a processing element. Serves
//             reads (1-cycle latency, valid strobe) and writes, forwards a
//             same-cycle write to a same-address read, flags out-of-range
//             accesses, and runs a self-timed clear of the partial-sum region.
//  Revision : 1.0 - initial release
// ============================================================================
module pe_scratchpad_responder #(
    parameter int DATA_WIDTH          = 16,
    parameter int ADDRESS_WIDTH       = 9,
    parameter int DEPTH               = 512,
    parameter int PARTIAL_SUM_ADDRESS = 500
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    pe_scratchpad_responder_if.slave  bus
);

    localparam logic [ADDRESS_WIDTH:0]   c_depth     = (ADDRESS_WIDTH+1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] c_last_addr = ADDRESS_WIDTH'(DEPTH - 1);
    localparam logic [ADDRESS_WIDTH-1:0] c_psum_addr = ADDRESS_WIDTH'(PARTIAL_SUM_ADDRESS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [ADDRESS_WIDTH-1:0] r_count;
    logic [DATA_WIDTH-1:0]    r_read_data;
    logic                     r_read_valid;
    logic                     r_addr_error;

    logic [DATA_WIDTH-1:0]    mem [0:DEPTH-1];

    logic w_busy;
    logic w_rd_accept;
    logic w_wr_accept;
    logic w_rd_oor;
    logic w_wr_oor;
    logic w_forward;

    // Requests are only taken while the clear engine is not sweeping memory.
    assign w_busy      = (r_state == ST_CLEAR);
    assign w_rd_accept = bus.read_request & ~w_busy;
    assign w_wr_accept = bus.write_enable & ~w_busy;
    assign w_rd_oor    = ({1'b0, bus.read_address}  >= c_depth);
    assign w_wr_oor    = ({1'b0, bus.write_address} >= c_depth);
    // A valid write landing on the address being read wins (write-first).
    assign w_forward   = w_wr_accept & ~w_wr_oor & (bus.write_address == bus.read_address);

    // Clear FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Clear FSM next-state: a start is only honoured from IDLE; the sweep ends
    // after the last implemented word is written.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.clear_start)          w_state_next = ST_CLEAR;
            ST_CLEAR: if (r_count == c_last_addr)   w_state_next = ST_DONE;
            ST_DONE:                                w_state_next = ST_IDLE;
            default:                                w_state_next = ST_IDLE;
        endcase
    end

    // Clear address counter: loads the region base on start and stops at the
    // last word, so it never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (r_state == ST_IDLE && bus.clear_start) begin
            r_count <= c_psum_addr;
        end else if (r_state == ST_CLEAR && r_count != c_last_addr) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Single memory write port shared by the clear engine and user writes;
    // the two never collide because user writes are blocked while clearing.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            mem[r_count] <= '0;
        end else if (w_wr_accept && !w_wr_oor) begin
            mem[bus.write_address] <= bus.write_data;
        end
    end

    // Read response pipeline and error strobe; read data holds between reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_addr_error <= 1'b0;
        end else begin
            r_read_valid <= w_rd_accept;
            r_addr_error <= (w_rd_accept & w_rd_oor) | (w_wr_accept & w_wr_oor);
            if (w_rd_accept) begin
                if (w_rd_oor) begin
                    r_read_data <= '0;
                end else if (w_forward) begin
                    r_read_data <= bus.write_data;
                end else begin
                    r_read_data <= mem[bus.read_address];
                end
            end
        end
    end

    assign bus.read_data  = r_read_data;
    assign bus.read_valid = r_read_valid;
    assign bus.addr_error = r_addr_error;
    assign bus.ready      = ~w_busy;
    assign bus.clear_busy = w_busy;
    assign bus.clear_done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pe_scratchpad_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pe_scratchpad_responder
//  Purpose  : Directed self-checking bench for pe_scratchpad_responder.
//             Instance A uses default sizing; instance B is built with
//             DEPTH=400 to exercise out-of-range addresses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pe_scratchpad_responder;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    pe_scratchpad_responder_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(9)) a_if ();
    pe_scratchpad_responder_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(9)) b_if ();

    pe_scratchpad_responder #(
        .DATA_WIDTH(16), .ADDRESS_WIDTH(9), .DEPTH(512), .PARTIAL_SUM_ADDRESS(500)
    ) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if)
    );

    pe_scratchpad_responder #(
        .DATA_WIDTH(16), .ADDRESS_WIDTH(9), .DEPTH(400), .PARTIAL_SUM_ADDRESS(390)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [8:0] addr, input logic [15:0] data);
        a_if.write_enable  = 1'b1;
        a_if.write_address = addr;
        a_if.write_data    = data;
        tick();
        a_if.write_enable  = 1'b0;
    endtask

    task automatic read_a(input string tag, input logic [8:0] addr, input logic [15:0] exp);
        a_if.read_request = 1'b1;
        a_if.read_address = addr;
        tick();
        a_if.read_request = 1'b0;
        check({tag, "_valid"}, a_if.read_valid, 1);
        check({tag, "_data"},  a_if.read_data,  exp);
    endtask

    // Starts a clear on instance A and runs until clear_busy drops, returning
    // the busy length. Optionally issues a read of 499 on the start edge and
    // holds a read request throughout busy; optionally pokes clear_start mid-busy.
    task automatic clear_run(input bit with_read, input int poke_at, output int cycles);
        a_if.clear_start = 1'b1;
        if (with_read) begin
            a_if.read_request = 1'b1;
            a_if.read_address = 9'd499;
        end
        tick();
        a_if.clear_start = 1'b0;
        if (with_read) begin
            check("start_read_valid", a_if.read_valid, 1);
            check("start_read_data",  a_if.read_data,  16'h4999);
            a_if.read_address = 9'd3;
        end
        cycles = 0;
        while (a_if.clear_busy && cycles < 40) begin
            cycles++;
            check("busy_not_ready", a_if.ready, 0);
            if (with_read && cycles > 1) check("busy_no_valid", a_if.read_valid, 0);
            a_if.clear_start = (cycles == poke_at);
            tick();
        end
        a_if.clear_start  = 1'b0;
        a_if.read_request = 1'b0;
        if (with_read) check("busy_end_no_valid", a_if.read_valid, 0);
    endtask

    initial begin
        int cycles;

        a_if.read_request = 1'b0; a_if.read_address = '0;
        a_if.write_enable = 1'b0; a_if.write_address = '0; a_if.write_data = '0;
        a_if.clear_start  = 1'b0;
        b_if.read_request = 1'b0; b_if.read_address = '0;
        b_if.write_enable = 1'b0; b_if.write_address = '0; b_if.write_data = '0;
        b_if.clear_start  = 1'b0;

        // Reset values
        repeat (2) tick();
        check("rst_read_data",  a_if.read_data,  0);
        check("rst_read_valid", a_if.read_valid, 0);
        check("rst_addr_error", a_if.addr_error, 0);
        check("rst_clear_busy", a_if.clear_busy, 0);
        check("rst_clear_done", a_if.clear_done, 0);
        check("rst_ready",      a_if.ready,      1);
        reset = 1'b1;
        tick();

        // Write then read back
        write_a(9'd7, 16'h1234);
        read_a("wr_rd_7", 9'd7, 16'h1234);
        check("wr_rd_7_err", a_if.addr_error, 0);
        tick();
        check("idle_no_valid", a_if.read_valid, 0);
        check("idle_hold_data", a_if.read_data, 16'h1234);

        // Same-cycle write/read forwarding
        write_a(9'd20, 16'h0001);
        a_if.write_enable  = 1'b1; a_if.write_address = 9'd20; a_if.write_data = 16'hBEEF;
        a_if.read_request  = 1'b1; a_if.read_address  = 9'd20;
        tick();
        a_if.write_enable  = 1'b0; a_if.read_request  = 1'b0;
        check("fwd_valid", a_if.read_valid, 1);
        check("fwd_data",  a_if.read_data,  16'hBEEF);
        read_a("fwd_stored", 9'd20, 16'hBEEF);

        // Back-to-back pipelined reads
        write_a(9'd0, 16'h000A);
        write_a(9'd1, 16'h000B);
        write_a(9'd2, 16'h000C);
        a_if.read_request = 1'b1;
        a_if.read_address = 9'd0; tick();
        check("b2b_0_valid", a_if.read_valid, 1); check("b2b_0_data", a_if.read_data, 16'h000A);
        a_if.read_address = 9'd1; tick();
        check("b2b_1_valid", a_if.read_valid, 1); check("b2b_1_data", a_if.read_data, 16'h000B);
        a_if.read_address = 9'd2; tick();
        check("b2b_2_valid", a_if.read_valid, 1); check("b2b_2_data", a_if.read_data, 16'h000C);
        a_if.read_request = 1'b0;

        // Out-of-range accesses on the DEPTH=400 instance
        b_if.write_enable = 1'b1; b_if.write_address = 9'd10; b_if.write_data = 16'h7777;
        tick();
        b_if.write_enable = 1'b0;
        b_if.read_request = 1'b1; b_if.read_address = 9'd10;
        tick();
        b_if.read_request = 1'b0;
        check("b_rd10_data", b_if.read_data, 16'h7777);
        check("b_rd10_err",  b_if.addr_error, 0);
        b_if.write_enable = 1'b1; b_if.write_address = 9'd450; b_if.write_data = 16'h5555;
        tick();
        b_if.write_enable = 1'b0;
        check("oor_wr_err",   b_if.addr_error, 1);
        check("oor_wr_valid", b_if.read_valid, 0);
        tick();
        check("oor_err_pulse", b_if.addr_error, 0);
        b_if.read_request = 1'b1; b_if.read_address = 9'd450;
        tick();
        b_if.read_request = 1'b0;
        check("oor_rd_err",   b_if.addr_error, 1);
        check("oor_rd_valid", b_if.read_valid, 1);
        check("oor_rd_data",  b_if.read_data,  0);
        b_if.read_request = 1'b1; b_if.read_address = 9'd10;
        tick();
        b_if.read_request = 1'b0;
        check("b_rd10_again", b_if.read_data, 16'h7777);
        check("b_rd10_noerr", b_if.addr_error, 0);

        // Partial-sum clear
        for (int i = 500; i < 512; i++) write_a(9'(i), 16'hFFFF);
        write_a(9'd499, 16'h4999);
        clear_run(1'b1, 0, cycles);
        check("clr_busy_len",  cycles, 12);
        check("clr_done_high", a_if.clear_done, 1);
        check("clr_done_ready", a_if.ready, 1);
        tick();
        check("clr_done_pulse", a_if.clear_done, 0);
        check("clr_idle",       a_if.clear_busy, 0);
        for (int i = 500; i < 512; i++) read_a("clr_zero", 9'(i), 16'h0000);
        read_a("clr_keep_499", 9'd499, 16'h4999);
        read_a("clr_keep_2",   9'd2,   16'h000C);

        // Reset in the middle of a clear, then a full clear with a stray start
        write_a(9'd505, 16'h5050);
        a_if.clear_start = 1'b1;
        tick();
        a_if.clear_start = 1'b0;
        repeat (4) tick();
        check("mid_busy", a_if.clear_busy, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_busy",  a_if.clear_busy, 0);
        check("mid_rst_done",  a_if.clear_done, 0);
        check("mid_rst_ready", a_if.ready,      1);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("post_rst_no_done", a_if.clear_done, 0);
        end
        clear_run(1'b0, 4, cycles);
        check("reclr_busy_len",  cycles, 12);
        check("reclr_done_high", a_if.clear_done, 1);
        tick();
        check("reclr_done_pulse", a_if.clear_done, 0);
        check("reclr_not_queued", a_if.clear_busy, 0);
        read_a("reclr_zero_505", 9'd505, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/pe_scratchpad_responder.md
Name: pe_scratchpad_responder

Overview:
Memory-side responder for the processing-element scratchpad port. It serves single-cycle-issue read and write requests from the PE controller and returns read data with a fixed 1-cycle latency and a valid strobe. It also provides same-address write-to-read forwarding, out-of-range address detection, and a self-timed clear engine that zeroes the partial-sum region between layers.

Parameters:
DATA_WIDTH, 16, width of each stored word.
ADDRESS_WIDTH, 9, width of the read and write address ports.
DEPTH, 512, number of implemented words; must satisfy DEPTH <= 2**ADDRESS_WIDTH.
PARTIAL_SUM_ADDRESS, 500, first address of the partial-sum region cleared by the clear engine; must be < DEPTH.

Ports:
clk  input  1  sole clock; all logic is rising-edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
read_request  input  1  read strobe; sampled on the rising edge.
read_address  input  ADDRESS_WIDTH  read address; sampled with read_request.
write_enable  input  1  write strobe; sampled on the rising edge.
write_address  input  ADDRESS_WIDTH  write address.
write_data  input  DATA_WIDTH  write data.
read_data  output  DATA_WIDTH  registered read result.
read_valid  output  1  one-cycle pulse; read_data is valid while high.
addr_error  output  1  one-cycle pulse flagging an out-of-range access.
ready  output  1  high when requests are accepted; equals not clear_busy.
clear_start  input  1  request to zero the partial-sum region.
clear_busy  output  1  high while the clear engine is running.
clear_done  output  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset (reset=0): FSM goes to IDLE asynchronously. read_data=0, read_valid=0, addr_error=0, clear_busy=0, clear_done=0, ready=1. Memory array is not reset; its contents are undefined until written.
- Read accepted when read_request=1 and ready=1 at edge N:
  - read_valid=1 in cycle N+1 for exactly one cycle.
  - read_data = mem[read_address] in cycle N+1.
  - read_data holds its last value when no read is in progress.
- Write accepted when write_enable=1 and ready=1 at edge N: mem[write_address] <= write_data at edge N.
- Same-cycle read and write to the same valid address: read returns the new write_data (write-first forwarding).
- Back-to-back reads on consecutive cycles are fully pipelined: one result per cycle.
- Out-of-range address (address >= DEPTH):
  - Write: discarded, and addr_error pulses in N+1.
  - Read: read_valid still pulses, read_data=0, and addr_error pulses in N+1.
  - addr_error is the OR of both sources.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR when clear_start=1. The internal counter loads PARTIAL_SUM_ADDRESS and clear_busy=1 from the next cycle.
  - CLEAR: writes 0 to mem[counter] each cycle, then increments. After writing DEPTH-1, go to DONE. Duration is DEPTH-PARTIAL_SUM_ADDRESS cycles (12 at defaults).
  - DONE: clear_done=1 for one cycle, clear_busy=0, then return to IDLE.
  - clear_start while in CLEAR or DONE is ignored (not queued).
- While clear_busy=1:
  - ready=0; read_request and write_enable are ignored, producing no read_valid and no addr_error.
  - The requester must hold requests until ready=1.
  - A read accepted on the edge that starts the clear still completes normally in the next cycle.
- clear_start and a write in the same IDLE cycle: the write is accepted and committed, then the clear begins.
- Reset asserted mid-clear: FSM returns to IDLE and outputs take their reset values. Partially cleared contents remain undefined; no clear_done is produced.
- No arithmetic is performed on data; the counter is ADDRESS_WIDTH bits wide and never wraps past DEPTH-1.

Test Plan:
- Write 0x1234 to address 7, then read address 7 the next cycle -> read_valid=1 one cycle later with read_data=0x1234, addr_error=0.
- Same-cycle write 0xBEEF and read at address 20 (old value 0x0001) -> next-cycle read_data=0xBEEF.
- Reads of addresses 0, 1, 2 on three consecutive cycles (preloaded 0xA, 0xB, 0xC) -> read_valid high three cycles with 0xA, 0xB, 0xC in order.
- With DEPTH=400, write to 450, then read 450 -> write ignored, each access gives an addr_error pulse, read_data=0, read_valid=1.
- Preload 0xFFFF at 500..511, pulse clear_start -> clear_busy high 12 cycles, clear_done one pulse, reads of 500..511 return 0, address 499 unchanged; a read issued during busy gets no read_valid.
- Assert reset at cycle 5 of a clear -> clear_busy=0, clear_done never pulses, ready=1; a subsequent clear_start completes a full 12-cycle clear.
